id_ex_stage_reg: RTL and testbench

- Pipeline register between instruction decode (controller + register file + sign extender) and execute.
- Captures the decode control word and operand data on each clock edge.
- Contains load-use hazard detection: stalls the PC and IF/ID register for one cycle and injects a bubble into EX.
- Honours a flush request from branch/jump resolution.

---
 rtl/id_ex_stage_reg.sv | 175 +++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and flush handling.
// A load in EX whose destination matches a source of the decode instruction
// raises Stall for one cycle and a bubble is inserted into EX instead.
// Optional macro ID_EX_PC_TRACE_EN adds a traced PC field (ID_PC/EX_PC)
// and a saturating BubbleCount of stall/flush bubbles.
module id_ex_stage_reg #(
  parameter int          DATA_W     = 32,
  parameter int          REG_AW     = 5,
  parameter logic [3:0]  BUBBLE_SEL = 4'd10
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              ID_RegDst,
  input  logic              ID_ALUSrc0,
  input  logic [1:0]        ID_ALUSrc1,
  input  logic              ID_R_Enable,
  input  logic              ID_W_Enable,
  input  logic              ID_MemToReg,
  input  logic              ID_RegWrite,
  input  logic [1:0]        ID_R_Width,
  input  logic [1:0]        ID_W_Width,
  input  logic [3:0]        ID_InstrSel,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [DATA_W-1:0] ID_PCPlus4,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic [REG_AW-1:0] ID_Rd,
  input  logic              ID_UsesRt,
`ifdef ID_EX_PC_TRACE_EN
  input  logic [31:0]       ID_PC,
  output logic [31:0]       EX_PC,
  output logic [31:0]       BubbleCount,
`endif
  output logic              EX_RegDst,
  output logic              EX_ALUSrc0,
  output logic [1:0]        EX_ALUSrc1,
  output logic              EX_R_Enable,
  output logic              EX_W_Enable,
  output logic              EX_MemToReg,
  output logic              EX_RegWrite,
  output logic [1:0]        EX_R_Width,
  output logic [1:0]        EX_W_Width,
  output logic [3:0]        EX_InstrSel,
  output logic [DATA_W-1:0] EX_ReadData1,
  output logic [DATA_W-1:0] EX_ReadData2,
  output logic [DATA_W-1:0] EX_Imm,
  output logic [DATA_W-1:0] EX_PCPlus4,
  output logic [REG_AW-1:0] EX_Rs,
  output logic [REG_AW-1:0] EX_Rt,
  output logic [REG_AW-1:0] EX_Rd,
  output logic              EX_Valid,
  output logic              Stall
);

  logic              r_regDst;
  logic              r_aluSrc0;
  logic [1:0]        r_aluSrc1;
  logic              r_rEnable;
  logic              r_wEnable;
  logic              r_memToReg;
  logic              r_regWrite;
  logic [1:0]        r_rWidth;
  logic [1:0]        r_wWidth;
  logic [3:0]        r_instrSel;
  logic [DATA_W-1:0] r_readData1;
  logic [DATA_W-1:0] r_readData2;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pcPlus4;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic              r_valid;
`ifdef ID_EX_PC_TRACE_EN
  logic [31:0]       r_pc;
  logic [31:0]       r_bubbleCount;
`endif

  logic w_stall;
  logic w_bubble;

  // Load-use detection: a live load in EX writing a non-zero register that
  // the decode instruction reads. A flush discards the decode instruction,
  // so there is nothing to hold.
  assign w_stall = ~Flush & r_valid & r_rEnable & (r_rt != '0) &
                   ((r_rt == ID_Rs) | (ID_UsesRt & (r_rt == ID_Rt)));

  assign w_bubble = Flush | w_stall;

  // Pipeline register: reset or bubble clears the slot, otherwise capture ID.
  always_ff @(posedge Clk) begin
    if (Rst || w_bubble) begin
      r_regDst    <= 1'b0;
      r_aluSrc0   <= 1'b0;
      r_aluSrc1   <= 2'd0;
      r_rEnable   <= 1'b0;
      r_wEnable   <= 1'b0;
      r_memToReg  <= 1'b0;
      r_regWrite  <= 1'b0;
      r_rWidth    <= 2'd0;
      r_wWidth    <= 2'd0;
      r_instrSel  <= BUBBLE_SEL;
      r_readData1 <= '0;
      r_readData2 <= '0;
      r_imm       <= '0;
      r_pcPlus4   <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_valid     <= 1'b0;
`ifdef ID_EX_PC_TRACE_EN
      r_pc        <= 32'd0;
`endif
    end else begin
      r_regDst    <= ID_RegDst;
      r_aluSrc0   <= ID_ALUSrc0;
      r_aluSrc1   <= ID_ALUSrc1;
      r_rEnable   <= ID_R_Enable;
      r_wEnable   <= ID_W_Enable;
      r_memToReg  <= ID_MemToReg;
      r_regWrite  <= ID_RegWrite;
      r_rWidth    <= ID_R_Width;
      r_wWidth    <= ID_W_Width;
      r_instrSel  <= ID_InstrSel;
      r_readData1 <= ID_ReadData1;
      r_readData2 <= ID_ReadData2;
      r_imm       <= ID_Imm;
      r_pcPlus4   <= ID_PCPlus4;
      r_rs        <= ID_Rs;
      r_rt        <= ID_Rt;
      r_rd        <= ID_Rd;
      r_valid     <= 1'b1;
`ifdef ID_EX_PC_TRACE_EN
      r_pc        <= ID_PC;
`endif
    end
  end

`ifdef ID_EX_PC_TRACE_EN
  // Count bubbles inserted for stall or flush, saturating at all-ones.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_bubbleCount <= 32'd0;
    end else if (w_bubble && (r_bubbleCount != 32'hFFFF_FFFF)) begin
      r_bubbleCount <= r_bubbleCount + 32'd1;
    end
  end

  assign EX_PC       = r_pc;
  assign BubbleCount = r_bubbleCount;
`endif

  assign EX_RegDst    = r_regDst;
  assign EX_ALUSrc0   = r_aluSrc0;
  assign EX_ALUSrc1   = r_aluSrc1;
  assign EX_R_Enable  = r_rEnable;
  assign EX_W_Enable  = r_wEnable;
  assign EX_MemToReg  = r_memToReg;
  assign EX_RegWrite  = r_regWrite;
  assign EX_R_Width   = r_rWidth;
  assign EX_W_Width   = r_wWidth;
  assign EX_InstrSel  = r_instrSel;
  assign EX_ReadData1 = r_readData1;
  assign EX_ReadData2 = r_readData2;
  assign EX_Imm       = r_imm;
  assign EX_PCPlus4   = r_pcPlus4;
  assign EX_Rs        = r_rs;
  assign EX_Rt        = r_rt;
  assign EX_Rd        = r_rd;
  assign EX_Valid     = r_valid;
  assign Stall        = w_stall;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Testbench for id_ex_stage_reg: directed hazard/flush/reset sequences
// followed by randomized decode traffic, scored against a queue of expected
// EX slot contents computed from the pipeline-register rules.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        regDst;
    logic        aluSrc0;
    logic [1:0]  aluSrc1;
    logic        rEnable;
    logic        wEnable;
    logic        memToReg;
    logic        regWrite;
    logic [1:0]  rWidth;
    logic [1:0]  wWidth;
    logic [3:0]  instrSel;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] imm;
    logic [31:0] pcPlus4;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        usesRt;
  } instr_t;

  typedef struct packed {
    logic        valid;
    instr_t      ins;
  } slot_t;

  typedef struct {
    slot_t       slot;
    logic [31:0] bubbles;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  instr_t      idIns;
  logic        exRegDst, exAluSrc0, exREnable, exWEnable, exMemToReg, exRegWrite, exValid, stall;
  logic [1:0]  exAluSrc1, exRWidth, exWWidth;
  logic [3:0]  exInstrSel;
  logic [31:0] exReadData1, exReadData2, exImm, exPcPlus4;
  logic [4:0]  exRs, exRt, exRd;
  logic [31:0] exPc;
  logic [31:0] bubbleCount;

  int checks = 0;
  int errors = 0;

  expect_t expQ[$];
  slot_t   model;
  logic [31:0] modelBubbles;
  bit      stimDone = 1'b0;

  always #5 clk = ~clk;

`ifndef ID_EX_PC_TRACE_EN
  assign exPc        = 32'd0;
  assign bubbleCount = 32'd0;
`endif

  id_ex_stage_reg dut (
    .Clk          (clk),
    .Rst          (rst),
    .Flush        (flush),
    .ID_RegDst    (idIns.regDst),
    .ID_ALUSrc0   (idIns.aluSrc0),
    .ID_ALUSrc1   (idIns.aluSrc1),
    .ID_R_Enable  (idIns.rEnable),
    .ID_W_Enable  (idIns.wEnable),
    .ID_MemToReg  (idIns.memToReg),
    .ID_RegWrite  (idIns.regWrite),
    .ID_R_Width   (idIns.rWidth),
    .ID_W_Width   (idIns.wWidth),
    .ID_InstrSel  (idIns.instrSel),
    .ID_ReadData1 (idIns.readData1),
    .ID_ReadData2 (idIns.readData2),
    .ID_Imm       (idIns.imm),
    .ID_PCPlus4   (idIns.pcPlus4),
    .ID_Rs        (idIns.rs),
    .ID_Rt        (idIns.rt),
    .ID_Rd        (idIns.rd),
    .ID_UsesRt    (idIns.usesRt),
`ifdef ID_EX_PC_TRACE_EN
    .ID_PC        (idIns.pc),
    .EX_PC        (exPc),
    .BubbleCount  (bubbleCount),
`endif
    .EX_RegDst    (exRegDst),
    .EX_ALUSrc0   (exAluSrc0),
    .EX_ALUSrc1   (exAluSrc1),
    .EX_R_Enable  (exREnable),
    .EX_W_Enable  (exWEnable),
    .EX_MemToReg  (exMemToReg),
    .EX_RegWrite  (exRegWrite),
    .EX_R_Width   (exRWidth),
    .EX_W_Width   (exWWidth),
    .EX_InstrSel  (exInstrSel),
    .EX_ReadData1 (exReadData1),
    .EX_ReadData2 (exReadData2),
    .EX_Imm       (exImm),
    .EX_PCPlus4   (exPcPlus4),
    .EX_Rs        (exRs),
    .EX_Rt        (exRt),
    .EX_Rd        (exRd),
    .EX_Valid     (exValid),
    .Stall        (stall)
  );

  // An empty EX slot: nothing valid, all fields zero, non-branch select code.
  function automatic slot_t emptySlot();
    slot_t s;
    s = '0;
    s.ins.instrSel = 4'd10;
    return s;
  endfunction

  // What a real instruction looks like once it sits in EX.
  function automatic slot_t occupiedSlot(instr_t ins);
    slot_t s;
    s.valid = 1'b1;
    s.ins = ins;
    s.ins.usesRt = 1'b0;
`ifndef ID_EX_PC_TRACE_EN
    s.ins.pc = 32'd0;
`endif
    return s;
  endfunction

  // A load: reads memory, writes rt.
  function automatic instr_t makeLoad(logic [4:0] rt, logic [31:0] imm);
    instr_t i;
    i = '0;
    i.aluSrc1 = 2'd1;
    i.rEnable = 1'b1;
    i.memToReg = 1'b1;
    i.regWrite = 1'b1;
    i.rWidth = 2'd2;
    i.instrSel = 4'd0;
    i.rs = 5'd1;
    i.rt = rt;
    i.imm = imm;
    i.readData1 = $urandom;
    i.pcPlus4 = $urandom;
    i.pc = $urandom;
    return i;
  endfunction

  // An R-type consumer reading rs and rt.
  function automatic instr_t makeAlu(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    instr_t i;
    i = '0;
    i.regDst = 1'b1;
    i.regWrite = 1'b1;
    i.instrSel = 4'd1;
    i.rs = rs;
    i.rt = rt;
    i.rd = rd;
    i.usesRt = 1'b1;
    i.readData1 = $urandom;
    i.readData2 = $urandom;
    i.pcPlus4 = $urandom;
    i.pc = $urandom;
    return i;
  endfunction

  // Fully random decode word with register numbers kept small so hazards occur.
  function automatic instr_t makeRandom();
    instr_t i;
    i.regDst = 1'($urandom);
    i.aluSrc0 = 1'($urandom);
    i.aluSrc1 = 2'($urandom_range(0, 2));
    i.rEnable = 1'($urandom);
    i.wEnable = 1'($urandom);
    i.memToReg = 1'($urandom);
    i.regWrite = 1'($urandom);
    i.rWidth = 2'($urandom);
    i.wWidth = 2'($urandom);
    i.instrSel = 4'($urandom);
    i.readData1 = $urandom;
    i.readData2 = $urandom;
    i.imm = $urandom;
    i.pcPlus4 = $urandom;
    i.pc = $urandom;
    i.rs = 5'($urandom_range(0, 3));
    i.rt = 5'($urandom_range(0, 3));
    i.rd = 5'($urandom);
    i.usesRt = 1'($urandom);
    return i;
  endfunction

  // Drive one cycle of decode inputs, check Stall against the load-use rule,
  // and queue the EX contents the next edge should produce.
  task automatic applyStimulus(input logic r, input logic f, input instr_t ins,
                               output logic expStall);
    expect_t e;
    @(negedge clk);
    rst = r;
    flush = f;
    idIns = ins;
    #1;
    expStall = !f && model.valid && model.ins.rEnable && (model.ins.rt != 5'd0) &&
               ((model.ins.rt == ins.rs) || (ins.usesRt && (model.ins.rt == ins.rt)));
    checkOutput("stall", {31'd0, stall}, {31'd0, expStall});
    if (r) begin
      model = emptySlot();
      modelBubbles = 32'd0;
    end else if (f || expStall) begin
      model = emptySlot();
      if (modelBubbles != 32'hFFFF_FFFF) modelBubbles = modelBubbles + 32'd1;
    end else begin
      model = occupiedSlot(ins);
    end
    e.slot = model;
    e.bubbles = modelBubbles;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every edge the DUT presents a new EX slot; compare it with the
  // oldest expectation in the scoreboard.
  initial begin
    slot_t   obs;
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        obs.valid = exValid;
        obs.ins = {exRegDst, exAluSrc0, exAluSrc1, exREnable, exWEnable, exMemToReg,
                   exRegWrite, exRWidth, exWWidth, exInstrSel, exReadData1, exReadData2,
                   exImm, exPcPlus4, exPc, exRs, exRt, exRd, 1'b0};
        checks++;
        if (obs !== e.slot) begin
          errors++;
          $display("[TB] FAIL exSlot actual=%h required=%h", obs, e.slot);
        end
`ifdef ID_EX_PC_TRACE_EN
        checkOutput("bubbleCount", bubbleCount, e.bubbles);
`endif
      end
    end
  end

  // Stimulus: directed scenarios first, then random traffic in which the
  // decode instruction is held upstream whenever a stall is expected.
  initial begin
    instr_t ins;
    logic   s;
    logic   lastStall;
    int     waitCycles;
    rst = 1'b1;
    flush = 1'b0;
    idIns = '0;
    model = emptySlot();
    modelBubbles = 32'd0;
    @(posedge clk);

    applyStimulus(1'b1, 1'b0, makeAlu(5'd8, 5'd8, 5'd3), s);
    applyStimulus(1'b1, 1'b0, makeLoad(5'd8, 32'h4), s);

    // lw $8 then a consumer of $8: one stall, bubble, then the consumer enters.
    applyStimulus(1'b0, 1'b0, makeLoad(5'd8, 32'h4), s);
    ins = makeAlu(5'd8, 5'd2, 5'd4);
    applyStimulus(1'b0, 1'b0, ins, s);
    checkOutput("stallRaised", {31'd0, s}, 32'd1);
    applyStimulus(1'b0, 1'b0, ins, s);
    checkOutput("stallDropped", {31'd0, s}, 32'd0);

    // Load into $0 followed by a $0 consumer never stalls.
    applyStimulus(1'b0, 1'b0, makeLoad(5'd0, 32'h8), s);
    applyStimulus(1'b0, 1'b0, makeAlu(5'd0, 5'd0, 5'd5), s);

    // Dependency via rt only.
    applyStimulus(1'b0, 1'b0, makeLoad(5'd6, 32'hC), s);
    ins = makeAlu(5'd1, 5'd6, 5'd7);
    applyStimulus(1'b0, 1'b0, ins, s);
    applyStimulus(1'b0, 1'b0, ins, s);

    // Flush with a hazard present: flush bubble only.
    applyStimulus(1'b0, 1'b0, makeLoad(5'd8, 32'h10), s);
    applyStimulus(1'b0, 1'b1, makeAlu(5'd8, 5'd8, 5'd9), s);

    // Reset while a stall is pending.
    applyStimulus(1'b0, 1'b0, makeLoad(5'd9, 32'h14), s);
    applyStimulus(1'b1, 1'b0, makeAlu(5'd9, 5'd0, 5'd2), s);
    applyStimulus(1'b0, 1'b0, makeAlu(5'd9, 5'd0, 5'd2), s);

    lastStall = 1'b0;
    ins = makeRandom();
    for (int n = 0; n < 400; n++) begin
      if (!lastStall) begin
        ins = makeRandom();
        if ($urandom_range(0, 2) == 0) ins.rEnable = 1'b1;
      end
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0), ins, lastStall);
    end

    @(negedge clk);
    rst = 1'b0;
    flush = 1'b1;
    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("drained", expQ.size(), 32'd0);
    stimDone = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #200000;
    if (!stimDone) begin
      $display("[TB] FAIL timeout actual=running required=done");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

endmodule
